// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking.
// Drives registered crossbar selects/valids and per-input grant pulses.
module switch_allocator #(
    parameter int INPUT_NUM  = 4,
    parameter int OUTPUT_NUM = 4,
    localparam int SEL_SIZE  = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1,
    localparam int DEST_SIZE = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [INPUT_NUM-1:0]                 req_i,
    input  logic [INPUT_NUM-1:0][DEST_SIZE-1:0]  dest_i,
    input  logic [INPUT_NUM-1:0]                 tail_i,
    input  logic [OUTPUT_NUM-1:0]                out_ready_i,
    output logic [INPUT_NUM-1:0]                 grant_o,
    output logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  sel_o,
    output logic [OUTPUT_NUM-1:0]                valid_o,
    output logic [OUTPUT_NUM-1:0]                lock_state
);

    // Handshake: an input holds req/dest/tail stable until it sees grant_o
    // (one cycle after the sampling edge); one grant moves exactly one flit.
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                             state_q [OUTPUT_NUM];
    logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0] owner_q;
    logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0] ptr_q;

    logic [OUTPUT_NUM-1:0]               gnt_valid;
    logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0] gnt_idx;
    logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0] gnt_next_ptr;
    logic [INPUT_NUM-1:0]                grant_d;
    int                                  k;

    always_comb begin
        gnt_valid    = '0;
        gnt_idx      = '0;
        gnt_next_ptr = '0;
        grant_d      = '0;
        k            = 0;
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            if (out_ready_i[o]) begin
                if (state_q[o] == LOCKED) begin
                    if (req_i[owner_q[o]] && dest_i[owner_q[o]] == DEST_SIZE'(o)) begin
                        gnt_valid[o] = 1'b1;
                        gnt_idx[o]   = owner_q[o];
                    end
                end else begin
                    // Scan downward so the last match written is the first one from ptr.
                    for (int s = INPUT_NUM - 1; s >= 0; s--) begin
                        k = (int'(ptr_q[o]) + s) % INPUT_NUM;
                        if (req_i[k] && dest_i[k] == DEST_SIZE'(o)) begin
                            gnt_valid[o]    = 1'b1;
                            gnt_idx[o]      = SEL_SIZE'(k);
                            gnt_next_ptr[o] = SEL_SIZE'((k + 1) % INPUT_NUM);
                        end
                    end
                end
            end
            if (gnt_valid[o]) begin
                grant_d[gnt_idx[o]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_o <= '0;
            valid_o <= '0;
            sel_o   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            for (int o = 0; o < OUTPUT_NUM; o++) begin
                state_q[o] <= IDLE;
            end
        end else begin
            grant_o <= grant_d;
            valid_o <= gnt_valid;
            for (int o = 0; o < OUTPUT_NUM; o++) begin
                if (gnt_valid[o]) begin
                    sel_o[o] <= gnt_idx[o];
                    if (state_q[o] == IDLE) begin
                        ptr_q[o] <= gnt_next_ptr[o];
                        if (!tail_i[gnt_idx[o]]) begin
                            state_q[o] <= LOCKED;
                            owner_q[o] <= gnt_idx[o];
                        end
                    end else if (tail_i[gnt_idx[o]]) begin
                        state_q[o] <= IDLE;
                    end
                end
            end
        end
    end

    always_comb begin
        lock_state = '0;
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            lock_state[o] = (state_q[o] == LOCKED);
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios with literal expectations,
// then randomized wormhole traffic checked every cycle against a reference model.
module tb_switch_allocator;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int EW = 4 + 4 + 8 + 4;

    logic             clk;
    logic             rst;
    logic [NI-1:0]    req_i;
    logic [NI-1:0][1:0] dest_i;
    logic [NI-1:0]    tail_i;
    logic [NO-1:0]    out_ready_i;
    logic [NI-1:0]    grant_o;
    logic [NO-1:0][1:0] sel_o;
    logic [NO-1:0]    valid_o;
    logic [NO-1:0]    lock_state;

    switch_allocator #(.INPUT_NUM(NI), .OUTPUT_NUM(NO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .dest_i(dest_i), .tail_i(tail_i),
        .out_ready_i(out_ready_i), .grant_o(grant_o), .sel_o(sel_o),
        .valid_o(valid_o), .lock_state(lock_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // reference model: per-output lock flag, owner and rr pointer
    int          m_ptr   [NO];
    int          m_owner [NO];
    int          m_sel   [NO];
    logic [NO-1:0] m_lock;
    logic [NI-1:0] m_grant;
    logic [NO-1:0] m_valid;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_word;
    logic [7:0]    sel_pk;

    task automatic model_reset();
        for (int o = 0; o < NO; o++) begin
            m_ptr[o] = 0; m_owner[o] = 0; m_sel[o] = 0;
        end
        m_lock = '0;
    endtask

    task automatic model_step();
        int who;
        m_grant = '0;
        m_valid = '0;
        for (int o = 0; o < NO; o++) begin
            who = -1;
            if (out_ready_i[o]) begin
                if (m_lock[o]) begin
                    if (req_i[m_owner[o]] && int'(dest_i[m_owner[o]]) == o) who = m_owner[o];
                end else begin
                    for (int s = 0; s < NI && who < 0; s++) begin
                        if (req_i[(m_ptr[o] + s) % NI] && int'(dest_i[(m_ptr[o] + s) % NI]) == o)
                            who = (m_ptr[o] + s) % NI;
                    end
                end
            end
            if (who >= 0) begin
                m_grant[who] = 1'b1;
                m_valid[o]   = 1'b1;
                m_sel[o]     = who;
                if (m_lock[o]) begin
                    if (tail_i[who]) m_lock[o] = 1'b0;
                end else begin
                    m_ptr[o] = (who + 1) % NI;
                    if (!tail_i[who]) begin
                        m_lock[o]  = 1'b1;
                        m_owner[o] = who;
                    end
                end
            end
        end
        for (int o = 0; o < NO; o++) sel_pk[2*o +: 2] = 2'(m_sel[o]);
    endtask

    initial model_reset();
    always @(negedge rst) model_reset();

    // scoreboard: expected word pushed at the edge, compared just after it
    always @(posedge clk) begin
        if (rst) begin
            model_step();
            exp_q.push_back({m_lock, m_valid, sel_pk, m_grant});
            #1;
            exp_word = exp_q.pop_front();
            check("sb_grant", 32'(grant_o),    32'(exp_word[3:0]));
            check("sb_sel",   32'(sel_o),      32'(exp_word[11:4]));
            check("sb_valid", 32'(valid_o),    32'(exp_word[15:12]));
            check("sb_lock",  32'(lock_state), 32'(exp_word[19:16]));
        end
    end

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        req_i = '0; dest_i = '0; tail_i = '0; out_ready_i = '1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    int          active [NI];
    int          pdest  [NI];
    int          rem    [NI];
    logic [3:0]  t3_exp [6];

    initial begin
        t3_exp[0] = 4'b0001; t3_exp[1] = 4'b0010; t3_exp[2] = 4'b1000;
        t3_exp[3] = 4'b0001; t3_exp[4] = 4'b0010; t3_exp[5] = 4'b1000;
        rst = 1'b0;
        idle_inputs();
        do_reset();
        check("rst_grant", 32'(grant_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_sel",   32'(sel_o),   0);
        check("rst_lock",  32'(lock_state), 0);

        // single request, then rr pointer of out 1 must sit at 3
        req_i = 4'b0100; dest_i[2] = 2'd1; tail_i = 4'b1111;
        cycle();
        check("t2_grant", 32'(grant_o), 32'b0100);
        check("t2_sel1",  32'(sel_o[1]), 2);
        check("t2_valid", 32'(valid_o), 32'b0010);
        req_i = 4'b1001; dest_i = '0; dest_i[0] = 2'd1; dest_i[3] = 2'd1;
        cycle();
        check("t2_ptr_grant", 32'(grant_o), 32'b1000);

        // round robin on out 0 among inputs 0,1,3
        do_reset();
        req_i = 4'b1011; dest_i = '0; tail_i = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            cycle();
            check("t3_grant", 32'(grant_o), 32'(t3_exp[c]));
            check("t3_valid0", 32'(valid_o[0]), 1);
        end
        // asynchronous reset with grants in flight
        rst = 1'b0;
        #1;
        check("t1_grant", 32'(grant_o), 0);
        check("t1_valid", 32'(valid_o), 0);
        check("t1_sel",   32'(sel_o),   0);
        #1;
        rst = 1'b1;
        idle_inputs();
        cycle();

        // wormhole lock: 3-flit packet from input 1 to out 2
        do_reset();
        req_i = 4'b0010; dest_i[1] = 2'd2; tail_i = 4'b0000;
        cycle();
        check("t4_head", 32'(grant_o), 32'b0010);
        req_i = 4'b0011; dest_i[0] = 2'd2; tail_i = 4'b0001;
        cycle();
        check("t4_body", 32'(grant_o), 32'b0010);
        tail_i = 4'b0011;
        cycle();
        check("t4_tail", 32'(grant_o), 32'b0010);
        req_i = 4'b0001;
        cycle();
        check("t4_other", 32'(grant_o), 32'b0001);
        idle_inputs();
        cycle();

        // backpressure on out 3
        do_reset();
        req_i = 4'b0001; dest_i[0] = 2'd3; tail_i = 4'b0001; out_ready_i = 4'b0111;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("t5_stall_grant", 32'(grant_o), 0);
            check("t5_stall_valid3", 32'(valid_o[3]), 0);
        end
        out_ready_i = 4'b1111;
        cycle();
        check("t5_grant", 32'(grant_o), 32'b0001);
        check("t5_valid", 32'(valid_o), 32'b1000);
        idle_inputs();
        cycle();

        // reset mid-packet releases the lock
        do_reset();
        req_i = 4'b0100; dest_i[2] = 2'd1; tail_i = 4'b0000;
        cycle();
        check("t6_head", 32'(grant_o), 32'b0100);
        check("t6_locked", 32'(lock_state), 32'b0010);
        req_i = 4'b0001; dest_i = '0; dest_i[0] = 2'd1; tail_i = 4'b0001;
        cycle();
        check("t6_blocked", 32'(grant_o), 0);
        rst = 1'b0;
        #1;
        check("t6_rst_lock", 32'(lock_state), 0);
        check("t6_rst_sel",  32'(sel_o), 0);
        #1;
        rst = 1'b1;
        cycle();
        check("t6_grant", 32'(grant_o), 32'b0001);
        check("t6_valid", 32'(valid_o), 32'b0010);

        // randomized wormhole traffic
        do_reset();
        for (int i = 0; i < NI; i++) begin
            active[i] = 0; pdest[i] = 0; rem[i] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NI; i++) begin
                if (active[i] != 0 && grant_o[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) active[i] = 0;
                end
            end
            if (c == 700) begin
                rst = 1'b0;
                #1;
                rst = 1'b1;
                for (int i = 0; i < NI; i++) active[i] = 0;
            end
            for (int i = 0; i < NI; i++) begin
                if (active[i] == 0 && $urandom_range(0, 2) == 0) begin
                    active[i] = 1;
                    pdest[i]  = $urandom_range(0, NO - 1);
                    rem[i]    = $urandom_range(1, 3);
                end
                req_i[i]  = (active[i] != 0);
                dest_i[i] = 2'(pdest[i]);
                tail_i[i] = (rem[i] == 1);
            end
            out_ready_i = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
            cycle();
        end
        idle_inputs();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
